// File: rtl/rca_pkg.sv
// Shared definitions for the pipelined ripple-carry adder.
package rca_pkg;

  // Number of pipeline stages for a given operand width and chunk size.
  function automatic int calc_stages(input int width, input int chunk);
    return width / chunk;
  endfunction

  // Per-stage control record. The skewed operand and sum fields depend on
  // WIDTH, so rca_pipe wraps this record together with them.
  typedef struct packed {
    logic valid;   // stage holds a live transaction
    logic sub;     // mode captured at acceptance
    logic carry;   // carry out of the most recently added chunk
    logic ovf;     // carry-into-MSB xor carry-out of that chunk
  } stage_ctrl_t;

endpackage

// File: rtl/rca_chunk.sv
// Combinational W-bit ripple-carry adder slice used once per pipeline stage.
module rca_chunk #(
  parameter int W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout,
  output logic         c_msb
);

  logic [W:0] c;

  assign c[0] = cin;

  for (genvar gi = 0; gi < W; gi++) begin : g_bit
    assign sum[gi]  = a[gi] ^ b[gi] ^ c[gi];
    assign c[gi+1]  = (a[gi] & b[gi]) | (c[gi] & (a[gi] ^ b[gi]));
  end

  assign cout  = c[W];
  assign c_msb = c[W-1];

endmodule

// File: rtl/rca_pipe.sv
// Pipelined adder/subtractor: one CHUNK-bit slice per stage, operands and
// partial sums skewed through the stages, valid/ready with bubble collapsing.
module rca_pipe
  import rca_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic             in2,
  input  logic             sub,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [WIDTH:0]   out0,
  output logic             ovf,
  output logic             out_valid,
  input  logic             out_ready
);

  localparam int STAGES = calc_stages(WIDTH, CHUNK);

  if (CHUNK < 1 || (WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("rca_pipe: WIDTH must be a positive multiple of CHUNK");
  end

  // Full stage record: control bits plus raw operands (b is kept un-inverted,
  // sub selects the inversion per chunk) and the sum assembled so far.
  typedef struct packed {
    stage_ctrl_t      ctrl;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
  } stage_t;

  stage_t             st_reg  [STAGES];
  stage_t             st_next [STAGES];
  logic [STAGES-1:0]  load;
  logic [STAGES-1:0]  advance;

  for (genvar gi = 0; gi < STAGES; gi++) begin : g_stage
    stage_t           src;
    stage_t           nxt;
    logic [CHUNK-1:0] b_eff;
    logic [CHUNK-1:0] sum;
    logic             cout;
    logic             c_msb;

    if (gi == 0) begin : g_src_in
      // Subtraction is A + ~B + ~borrow, so the effective carry-in is in2^sub.
      assign src = '{ctrl: '{valid: in_valid, sub: sub, carry: in2 ^ sub, ovf: 1'b0},
                     a: in0, b: in1, s: '0};
    end else begin : g_src_prev
      assign src = st_reg[gi-1];
    end

    assign b_eff = src.ctrl.sub ? ~src.b[gi*CHUNK +: CHUNK] : src.b[gi*CHUNK +: CHUNK];

    rca_chunk #(.W(CHUNK)) u_chunk (
      .a     (src.a[gi*CHUNK +: CHUNK]),
      .b     (b_eff),
      .cin   (src.ctrl.carry),
      .sum   (sum),
      .cout  (cout),
      .c_msb (c_msb)
    );

    // Insert this stage's chunk result into the record handed to its register.
    always_comb begin
      nxt                       = src;
      nxt.ctrl.carry            = cout;
      nxt.ctrl.ovf              = c_msb ^ cout;
      nxt.s[gi*CHUNK +: CHUNK]  = sum;
    end

    assign st_next[gi] = nxt;
  end

  // Backpressure chain from the output toward stage 0: a stage advances when
  // it is valid and its consumer loads; it loads when empty or advancing.
  always_comb begin
    logic downstream;
    load       = '0;
    advance    = '0;
    downstream = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      advance[k] = st_reg[k].ctrl.valid && downstream;
      load[k]    = !st_reg[k].ctrl.valid || advance[k];
      downstream = load[k];
    end
  end

  // Stage registers; a stage not loading holds its contents unchanged.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < STAGES; k++) st_reg[k] <= '0;
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (load[k]) st_reg[k] <= st_next[k];
      end
    end
  end

  assign in_ready  = load[0];
  assign out_valid = st_reg[STAGES-1].ctrl.valid;
  assign out0      = {st_reg[STAGES-1].ctrl.carry, st_reg[STAGES-1].s};
  assign ovf       = st_reg[STAGES-1].ctrl.ovf;

endmodule

// File: tb/tb_rca_pipe.sv
// Self-checking bench for rca_pipe: directed vectors, streaming with
// backpressure, stall hold, and mid-flight reset; plus a single-stage build.
module tb_rca_pipe;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic [15:0] in0, in1;
  logic        in2, sub, in_valid, in_ready, out_valid, out_ready, ovf;
  logic [16:0] out0;

  logic [7:0]  b_in0, b_in1;
  logic        b_in2, b_sub, b_in_valid, b_in_ready, b_out_valid, b_out_ready, b_ovf;
  logic [8:0]  b_out0;

  rca_pipe #(.WIDTH(16), .CHUNK(4)) dut (
    .clk(clk), .rst(rst), .in0(in0), .in1(in1), .in2(in2), .sub(sub),
    .in_valid(in_valid), .in_ready(in_ready), .out0(out0), .ovf(ovf),
    .out_valid(out_valid), .out_ready(out_ready)
  );

  rca_pipe #(.WIDTH(8), .CHUNK(8)) dut8 (
    .clk(clk), .rst(rst), .in0(b_in0), .in1(b_in1), .in2(b_in2), .sub(b_sub),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .out0(b_out0), .ovf(b_ovf),
    .out_valid(b_out_valid), .out_ready(b_out_ready)
  );

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic [15:0] a, b;
    logic        c, s;
    logic [16:0] e_out;
    logic        e_ovf;
  } vec_t;

  typedef struct {
    logic [7:0] a, b;
    logic       c, s;
    logic [8:0] e_out;
    logic       e_ovf;
  } vec8_t;

  typedef struct packed { logic [15:0] a, b; logic c, s; } txn_t;
  typedef struct packed { logic [16:0] out; logic ovf; } res_t;

  vec_t  vecs  [12];
  vec8_t vecs8 [3];
  txn_t  pend_q [$];
  res_t  exp_q  [$];

  logic        hold_prev = 1'b0;
  logic [16:0] hold_out;
  logic        hold_ovf;
  int          n_acc = 0;
  int          n_out = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // Reference: plain integer add/subtract, signed overflow from operand signs.
  function automatic res_t model(input txn_t t);
    res_t        r;
    logic [16:0] w;
    if (!t.s) begin
      w     = {1'b0, t.a} + {1'b0, t.b} + {16'd0, t.c};
      r.ovf = (t.a[15] == t.b[15]) && (w[15] != t.a[15]);
    end else begin
      w     = {1'b0, t.a} - {1'b0, t.b} - {16'd0, t.c};
      w[16] = ~w[16];
      r.ovf = (t.a[15] != t.b[15]) && (w[15] != t.a[15]);
    end
    r.out = w;
    return r;
  endfunction

  // One clock of queue-driven traffic, evaluated between edges.
  task automatic step(input logic ordy, input logic offer);
    res_t r;
    @(negedge clk);
    out_ready = ordy;
    if (offer && pend_q.size() > 0) begin
      in0 = pend_q[0].a; in1 = pend_q[0].b; in2 = pend_q[0].c; sub = pend_q[0].s;
      in_valid = 1'b1;
    end else begin
      in_valid = 1'b0;
    end
    #1;
    if (hold_prev) begin
      chk("hold_valid", 32'(out_valid), 32'd1);
      chk("hold_out0", 32'(out0), 32'(hold_out));
      chk("hold_ovf", 32'(ovf), 32'(hold_ovf));
    end
    hold_prev = out_valid && !out_ready;
    hold_out  = out0;
    hold_ovf  = ovf;
    if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL spurious_out: got out0=%0h, expected no result", out0);
      end else begin
        r = exp_q.pop_front();
        chk("stream_out0", 32'(out0), 32'(r.out));
        chk("stream_ovf", 32'(ovf), 32'(r.ovf));
        n_out++;
      end
    end
    if (in_valid && in_ready) begin
      exp_q.push_back(model(pend_q[0]));
      pend_q.delete(0);
      n_acc++;
    end
  endtask

  task automatic run_vec(input vec_t v);
    int lat;
    @(negedge clk);
    out_ready = 1'b1;
    in0 = v.a; in1 = v.b; in2 = v.c; sub = v.s; in_valid = 1'b1;
    #1;
    chk("vec_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    lat = 1;
    while (!out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("vec_latency", 32'(lat), 32'd4);
    chk("vec_out0", 32'(out0), 32'(v.e_out));
    chk("vec_ovf", 32'(ovf), 32'(v.e_ovf));
    @(posedge clk); #1;
    chk("vec_drained", 32'(out_valid), 32'd0);
  endtask

  task automatic run_vec8(input vec8_t v);
    int lat;
    @(negedge clk);
    b_in0 = v.a; b_in1 = v.b; b_in2 = v.c; b_sub = v.s; b_in_valid = 1'b1;
    @(posedge clk); #1;
    b_in_valid = 1'b0;
    lat = 1;
    while (!b_out_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
    chk("vec8_latency", 32'(lat), 32'd1);
    chk("vec8_out0", 32'(b_out0), 32'(v.e_out));
    chk("vec8_ovf", 32'(b_ovf), 32'(v.e_ovf));
    @(posedge clk); #1;
  endtask

  initial begin
    int   cyc;
    int   acc0, out_base;
    txn_t t;

    //          a         b         c     s     out0       ovf
    vecs[0]  = '{16'hFFFF, 16'h0001, 1'b0, 1'b0, 17'h10000, 1'b0};
    vecs[1]  = '{16'h0005, 16'h0003, 1'b0, 1'b1, 17'h10002, 1'b0};
    vecs[2]  = '{16'h0003, 16'h0005, 1'b0, 1'b1, 17'h0FFFE, 1'b0};
    vecs[3]  = '{16'h8000, 16'h0001, 1'b0, 1'b1, 17'h17FFF, 1'b1};
    vecs[4]  = '{16'h7FFF, 16'h0001, 1'b0, 1'b0, 17'h08000, 1'b1};
    vecs[5]  = '{16'h1234, 16'h4321, 1'b1, 1'b0, 17'h05556, 1'b0};
    vecs[6]  = '{16'h8000, 16'h8000, 1'b0, 1'b0, 17'h10000, 1'b1};
    vecs[7]  = '{16'h0000, 16'h0000, 1'b1, 1'b1, 17'h0FFFF, 1'b0};
    vecs[8]  = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 17'h1FFFF, 1'b0};
    vecs[9]  = '{16'h0000, 16'h8000, 1'b0, 1'b1, 17'h08000, 1'b1};
    vecs[10] = '{16'h00F0, 16'h0010, 1'b0, 1'b0, 17'h00100, 1'b0};
    vecs[11] = '{16'h1000, 16'h0001, 1'b0, 1'b1, 17'h10FFF, 1'b0};

    vecs8[0] = '{8'h7F, 8'h01, 1'b0, 1'b0, 9'h080, 1'b1};
    vecs8[1] = '{8'hFF, 8'h01, 1'b0, 1'b0, 9'h100, 1'b0};
    vecs8[2] = '{8'h00, 8'h01, 1'b0, 1'b1, 9'h0FF, 1'b0};

    rst = 1'b1;
    in0 = '0; in1 = '0; in2 = 1'b0; sub = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    b_in0 = '0; b_in1 = '0; b_in2 = 1'b0; b_sub = 1'b0; b_in_valid = 1'b0; b_out_ready = 1'b1;

    #12;
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out0", 32'(out0), 32'd0);
    chk("rst_ovf", 32'(ovf), 32'd0);
    chk("rst_out_valid8", 32'(b_out_valid), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);
    chk("post_rst_in_ready8", 32'(b_in_ready), 32'd1);

    // Directed vectors through the 4-stage build.
    for (int i = 0; i < 12; i++) run_vec(vecs[i]);

    // Single-stage build.
    for (int i = 0; i < 3; i++) run_vec8(vecs8[i]);

    // Full-rate stream: one result per cycle after a STAGES-cycle fill.
    for (int i = 0; i < 2000; i++) begin
      t.a = 16'($urandom()); t.b = 16'($urandom());
      t.c = 1'($urandom()); t.s = 1'($urandom());
      pend_q.push_back(t);
    end
    out_base = n_out;
    cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 3000) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("stream_cycles", 32'(cyc), 32'd2004);
    chk("stream_count", 32'(n_out - out_base), 32'd2000);

    // Random valid/ready traffic.
    for (int i = 0; i < 400; i++) begin
      t.a = 16'($urandom()); t.b = 16'($urandom());
      t.c = 1'($urandom()); t.s = 1'($urandom());
      pend_q.push_back(t);
    end
    cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 4000) begin
      step(1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 2) != 0));
      cyc++;
    end
    chk("rand_pend_left", 32'(pend_q.size()), 32'd0);
    chk("rand_exp_left", 32'(exp_q.size()), 32'd0);

    // Stall: 6 offered with out_ready low for 10 cycles.
    for (int i = 0; i < 6; i++) begin
      t.a = 16'(16'h1111 * (i + 1)); t.b = 16'(16'h0F0F + i);
      t.c = 1'(i); t.s = 1'(i >> 1);
      pend_q.push_back(t);
    end
    acc0 = n_acc;
    out_base = n_out;
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1);
    chk("stall_accepted", 32'(n_acc - acc0), 32'd4);
    chk("stall_in_ready", 32'(in_ready), 32'd0);
    chk("stall_out_valid", 32'(out_valid), 32'd1);
    cyc = 0;
    while ((pend_q.size() > 0 || exp_q.size() > 0) && cyc < 100) begin
      step(1'b1, 1'b1);
      cyc++;
    end
    chk("stall_delivered", 32'(n_out - out_base), 32'd6);

    // Reset with 3 transactions in flight.
    for (int i = 0; i < 3; i++) begin
      t.a = 16'h4000 + 16'(i); t.b = 16'h0123; t.c = 1'b0; t.s = 1'b0;
      pend_q.push_back(t);
    end
    for (int i = 0; i < 3; i++) step(1'b0, 1'b1);
    step(1'b0, 1'b0);
    @(posedge clk);
    @(negedge clk); #2;
    chk("pre_rst_out_valid", 32'(out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out0", 32'(out0), 32'd0);
    chk("mid_rst_ovf", 32'(ovf), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete();
    hold_prev = 1'b0;
    @(posedge clk); #1;
    chk("rel_in_ready", 32'(in_ready), 32'd1);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0);
    chk("rst_no_emit", 32'(out_valid), 32'd0);
    run_vec(vecs[5]);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_bad);
    $finish;
  end

endmodule
